// File: rtl/mag_sweep_pkg.sv
// Shared types and defaults for the magnitude-comparator sweep tester.
package mag_sweep_pkg;

  localparam int W_DEFAULT             = 4;
  localparam int SETTLE_CYCLES_DEFAULT = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } sweep_state_e;

endpackage

// File: rtl/mag_compare_sweep_if.sv
// Bundle between the sweep controller (master) and the comparator under test (slave).
interface mag_compare_sweep_if #(
  parameter int W = 4
);
  logic           start;
  logic [W-1:0]   A;
  logic [W-1:0]   B;
  logic           A_lt_B;
  logic           A_eq_B;
  logic           A_gt_B;
  logic           busy;
  logic           done;
  logic           pass;
  logic [2*W:0]   err_count;
  logic [W-1:0]   first_err_A;
  logic [W-1:0]   first_err_B;

  modport master (
    input  start, A_lt_B, A_eq_B, A_gt_B,
    output A, B, busy, done, pass, err_count, first_err_A, first_err_B
  );

  modport slave (
    output start, A_lt_B, A_eq_B, A_gt_B,
    input  A, B, busy, done, pass, err_count, first_err_A, first_err_B
  );
endinterface

// File: rtl/mag_compare_ref.sv
// Golden combinational magnitude comparator: exactly one of lt/eq/gt is high.
module mag_compare_ref #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         lt,
  output logic         eq,
  output logic         gt
);
  assign lt = (a < b);
  assign eq = (a == b);
  assign gt = (a > b);
endmodule

// File: rtl/mag_compare_sweep.sv
// Exhaustive sweep tester for an external W-bit magnitude comparator.
// Optional build macro MAG_SWEEP_STOP_ON_ERR_EN ends the sweep at the first mismatch.
module mag_compare_sweep
  import mag_sweep_pkg::*;
#(
  parameter int W             = W_DEFAULT,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT   // legal range 1..15
) (
  input  logic                clock,
  input  logic                reset,
  mag_compare_sweep_if.master bus
);
  localparam int          IDX_W       = 2 * W;
  localparam int          ERR_W       = 2 * W + 1;
  localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  sweep_state_e       state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic [3:0]         settle_q, settle_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [W-1:0]       fa_q, fa_d;
  logic [W-1:0]       fb_q, fb_d;

  logic exp_lt, exp_eq, exp_gt;
  logic mismatch;
  logic last_vec;

  mag_compare_ref #(.W(W)) u_ref (
    .a  (a_q),
    .b  (b_q),
    .lt (exp_lt),
    .eq (exp_eq),
    .gt (exp_gt)
  );

  // Any deviation from the golden one-hot triple counts, including 000 and multi-hot.
  assign mismatch = ({bus.A_lt_B, bus.A_eq_B, bus.A_gt_B} != {exp_lt, exp_eq, exp_gt});
  assign last_vec = (idx_q == {IDX_W{1'b1}});

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    settle_d = settle_q;
    err_d    = err_q;
    fa_d     = fa_q;
    fb_d     = fb_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d = ST_DRIVE;
          idx_d   = '0;
          err_d   = '0;
          fa_d    = '0;
          fb_d    = '0;
        end
      end
      ST_DRIVE: begin
        a_d      = idx_q[IDX_W-1:W];
        b_d      = idx_q[W-1:0];
        settle_d = '0;
        state_d  = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d = ST_CHECK;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      ST_CHECK: begin
        if (mismatch) begin
          err_d = err_q + ERR_W'(1);
          if (err_q == '0) begin
            fa_d = a_q;
            fb_d = b_q;
          end
        end
`ifdef MAG_SWEEP_STOP_ON_ERR_EN
        if (mismatch || last_vec) begin
`else
        if (last_vec) begin
`endif
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = ST_DRIVE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      settle_q <= '0;
      err_q    <= '0;
      fa_q     <= '0;
      fb_q     <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      settle_q <= settle_d;
      err_q    <= err_d;
      fa_q     <= fa_d;
      fb_q     <= fb_d;
    end
  end

  assign bus.A           = a_q;
  assign bus.B           = b_q;
  assign bus.busy        = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign bus.done        = (state_q == ST_DONE);
  assign bus.pass        = (state_q == ST_DONE) && (err_q == '0);
  assign bus.err_count   = err_q;
  assign bus.first_err_A = fa_q;
  assign bus.first_err_B = fb_q;
endmodule

// File: tb/tb_mag_compare_sweep.sv
// Self-checking bench: drives a behavioural comparator (with injectable faults) into two sweep testers.
module tb_mag_compare_sweep;
  import mag_sweep_pkg::*;

  localparam int W     = 4;
  localparam int NVEC  = 256;
  localparam int LIMIT = 5000;
`ifdef MAG_SWEEP_STOP_ON_ERR_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  mag_compare_sweep_if #(.W(W)) bus1 ();
  mag_compare_sweep_if #(.W(W)) bus3 ();

  mag_compare_sweep #(.W(W), .SETTLE_CYCLES(1)) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus1.master)
  );

  mag_compare_sweep #(.W(W), .SETTLE_CYCLES(3)) dut3 (
    .clock (clock),
    .reset (reset),
    .bus   (bus3.master)
  );

  // mode 0: ideal, 1: eq stuck at 0, 2: gt stuck at 1, 3: per-vector xor mask
  int         mode = 0;
  logic [2:0] mask [NVEC];
  logic [2:0] good1, flags1;

  always_comb begin
    good1  = {bus1.A < bus1.B, bus1.A == bus1.B, bus1.A > bus1.B};
    flags1 = good1;
    case (mode)
      1:       flags1 = {good1[2], 1'b0, good1[0]};
      2:       flags1 = {good1[2], good1[1], 1'b1};
      3:       flags1 = good1 ^ mask[{bus1.A, bus1.B}];
      default: flags1 = good1;
    endcase
  end
  assign bus1.A_lt_B = flags1[2];
  assign bus1.A_eq_B = flags1[1];
  assign bus1.A_gt_B = flags1[0];

  assign bus3.A_lt_B = (bus3.A < bus3.B);
  assign bus3.A_eq_B = (bus3.A == bus3.B);
  assign bus3.A_gt_B = (bus3.A > bus3.B);

  int total = 0;
  int bad   = 0;

  task automatic set_start(input int which, input logic v);
    if (which == 3) bus3.start = v;
    else            bus1.start = v;
  endtask

  // Pulse start, then count rising edges until done is seen (bounded).
  task automatic run_sweep(input int which, output int cyc);
    @(negedge clock);
    set_start(which, 1'b1);
    @(posedge clock); #1;
    set_start(which, 1'b0);
    cyc = 0;
    while (((which == 3) ? bus3.done : bus1.done) !== 1'b1 && cyc < LIMIT) begin
      @(posedge clock); #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    @(posedge clock); #1;
    total++;
    if ({bus1.A, bus1.B, bus1.busy, bus1.done, bus1.pass} !== '0) begin
      bad++;
      $display("FAIL reset_ctl: got A=%0d B=%0d busy=%b done=%b pass=%b, want all 0",
               bus1.A, bus1.B, bus1.busy, bus1.done, bus1.pass);
    end
    total++;
    if ({bus1.err_count, bus1.first_err_A, bus1.first_err_B} !== '0) begin
      bad++;
      $display("FAIL reset_err: got err=%0d first=(%0d,%0d), want 0", bus1.err_count,
               bus1.first_err_A, bus1.first_err_B);
    end
    @(negedge clock);
    reset = 1'b0;
    $display("reset: released");
  endtask

  task automatic test_clean_sweep;
    int cyc;
    mode = 0;
    run_sweep(1, cyc);
    total++;
    if (cyc !== 768) begin
      bad++;
      $display("FAIL clean_cycles: got %0d want 768", cyc);
    end
    total++;
    if (bus1.pass !== 1'b1 || bus1.err_count !== '0) begin
      bad++;
      $display("FAIL clean_pass: got pass=%b err=%0d want pass=1 err=0", bus1.pass, bus1.err_count);
    end
    total++;
    if (bus1.busy !== 1'b0) begin
      bad++;
      $display("FAIL clean_busy: got %b want 0", bus1.busy);
    end
    repeat (3) @(posedge clock);
    #1;
    total++;
    if (bus1.A !== 4'hF || bus1.B !== 4'hF || bus1.done !== 1'b1) begin
      bad++;
      $display("FAIL done_hold: got A=%0d B=%0d done=%b want 15 15 1", bus1.A, bus1.B, bus1.done);
    end
    $display("clean sweep: cycles=%0d pass=%b err=%0d", cyc, bus1.pass, bus1.err_count);
  endtask

  task automatic test_eq_stuck;
    int cyc;
    int exp_err;
    mode = 2'd1;
    run_sweep(1, cyc);
    exp_err = STOP ? 1 : 16;
    total++;
    if (bus1.err_count !== 9'(exp_err) || bus1.pass !== 1'b0) begin
      bad++;
      $display("FAIL eq_stuck_err: got err=%0d pass=%b want err=%0d pass=0", bus1.err_count,
               bus1.pass, exp_err);
    end
    total++;
    if (bus1.first_err_A !== 4'd0 || bus1.first_err_B !== 4'd0) begin
      bad++;
      $display("FAIL eq_stuck_first: got (%0d,%0d) want (0,0)", bus1.first_err_A, bus1.first_err_B);
    end
    $display("eq stuck 0: err=%0d first=(%0d,%0d)", bus1.err_count, bus1.first_err_A, bus1.first_err_B);
  endtask

  task automatic test_gt_stuck;
    int cyc;
    int exp_err;
    int exp_cyc;
    mode = 2;
    run_sweep(1, cyc);
    exp_err = STOP ? 1 : 136;
    exp_cyc = STOP ? 3 : 768;
    total++;
    if (bus1.err_count !== 9'(exp_err) || bus1.pass !== 1'b0) begin
      bad++;
      $display("FAIL gt_stuck_err: got err=%0d pass=%b want err=%0d pass=0", bus1.err_count,
               bus1.pass, exp_err);
    end
    total++;
    if (bus1.first_err_A !== 4'd0 || bus1.first_err_B !== 4'd0 || cyc !== exp_cyc) begin
      bad++;
      $display("FAIL gt_stuck_first: got (%0d,%0d) cyc=%0d want (0,0) cyc=%0d",
               bus1.first_err_A, bus1.first_err_B, cyc, exp_cyc);
    end
    $display("gt stuck 1: err=%0d cycles=%0d", bus1.err_count, cyc);
  endtask

  // Random sparse fault maps; expectations come from counting faulty vectors.
  task automatic test_random_faults;
    for (int it = 0; it < 4; it++) begin
      int cyc, n, errs, first, exp_err, exp_cyc, exp_a, exp_b;
      for (int i = 0; i < NVEC; i++) mask[i] = 3'b000;
      n = int'($urandom_range(1, 6));
      for (int k = 0; k < n; k++) begin
        int v;
        int a;
        int b;
        v = int'($urandom_range(0, NVEC - 1));
        a = v / 16;
        b = v % 16;
        // Iteration 0 forces an all-zero triple on one vector.
        if (it == 0 && k == 0) mask[v] = {a < b, a == b, a > b};
        else                   mask[v] = 3'($urandom_range(1, 7));
      end
      errs  = 0;
      first = -1;
      for (int i = 0; i < NVEC; i++) begin
        if (mask[i] != 3'b000) begin
          errs++;
          if (first < 0) first = i;
        end
      end
      exp_err = STOP ? 1 : errs;
      exp_cyc = STOP ? (first + 1) * 3 : 768;
      exp_a   = (first < 0) ? 0 : first / 16;
      exp_b   = (first < 0) ? 0 : first % 16;
      mode = 3;
      run_sweep(1, cyc);
      total++;
      if (bus1.err_count !== 9'(exp_err) || bus1.pass !== 1'b0 || cyc !== exp_cyc) begin
        bad++;
        $display("FAIL rand_err[%0d]: got err=%0d pass=%b cyc=%0d want err=%0d pass=0 cyc=%0d",
                 it, bus1.err_count, bus1.pass, cyc, exp_err, exp_cyc);
      end
      total++;
      if (bus1.first_err_A !== 4'(exp_a) || bus1.first_err_B !== 4'(exp_b)) begin
        bad++;
        $display("FAIL rand_first[%0d]: got (%0d,%0d) want (%0d,%0d)", it,
                 bus1.first_err_A, bus1.first_err_B, exp_a, exp_b);
      end
      $display("random faults %0d: faults=%0d err=%0d first=(%0d,%0d)", it, errs,
               bus1.err_count, bus1.first_err_A, bus1.first_err_B);
    end
    mode = 0;
  endtask

  task automatic test_mid_sweep_reset;
    int cyc;
    mode = 0;
    @(negedge clock);
    bus1.start = 1'b1;
    @(posedge clock); #1;
    bus1.start = 1'b0;
    repeat (299) @(posedge clock);
    #1;
    total++;
    if (bus1.busy !== 1'b1) begin
      bad++;
      $display("FAIL mid_busy: got %b want 1", bus1.busy);
    end
    reset = 1'b1;
    #1;
    total++;
    if ({bus1.A, bus1.B, bus1.busy, bus1.done, bus1.pass} !== '0 ||
        {bus1.err_count, bus1.first_err_A, bus1.first_err_B} !== '0) begin
      bad++;
      $display("FAIL mid_reset: got A=%0d B=%0d busy=%b done=%b err=%0d want all 0",
               bus1.A, bus1.B, bus1.busy, bus1.done, bus1.err_count);
    end
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    run_sweep(1, cyc);
    total++;
    if (cyc !== 768 || bus1.pass !== 1'b1) begin
      bad++;
      $display("FAIL after_reset: got cyc=%0d pass=%b want 768 1", cyc, bus1.pass);
    end
    $display("mid-sweep reset: resweep cycles=%0d pass=%b", cyc, bus1.pass);
  endtask

  task automatic test_start_while_busy;
    int  cyc;
    logic saw_idle;
    mode = 0;
    saw_idle = 1'b0;
    @(negedge clock);
    bus1.start = 1'b1;
    @(posedge clock); #1;
    bus1.start = 1'b0;
    cyc = 0;
    while (bus1.done !== 1'b1 && cyc < LIMIT) begin
      bus1.start = (cyc == 100);
      @(posedge clock); #1;
      cyc++;
      if (bus1.done !== 1'b1 && bus1.busy !== 1'b1) saw_idle = 1'b1;
    end
    bus1.start = 1'b0;
    total++;
    if (cyc !== 768 || saw_idle !== 1'b0 || bus1.pass !== 1'b1) begin
      bad++;
      $display("FAIL busy_start: got cyc=%0d idle_gap=%b pass=%b want 768 0 1", cyc, saw_idle,
               bus1.pass);
    end
    $display("start while busy: cycles=%0d", cyc);
  endtask

  task automatic test_settle3;
    int cyc;
    run_sweep(3, cyc);
    total++;
    if (cyc !== 1280 || bus3.pass !== 1'b1 || bus3.err_count !== '0) begin
      bad++;
      $display("FAIL settle3: got cyc=%0d pass=%b err=%0d want 1280 1 0", cyc, bus3.pass,
               bus3.err_count);
    end
    $display("settle=3 sweep: cycles=%0d pass=%b", cyc, bus3.pass);
  endtask

  initial begin
    bus1.start = 1'b0;
    bus3.start = 1'b0;
    for (int i = 0; i < NVEC; i++) mask[i] = 3'b000;
    test_reset();
    test_clean_sweep();
    test_eq_stuck();
    test_gt_stuck();
    test_random_faults();
    test_mid_sweep_reset();
    test_start_while_busy();
    test_settle3();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mag_compare_sweep.md
MAG_COMPARE_SWEEP -- requirements
Module: mag_compare_sweep

Interface
REQ-001 SHALL have parameter W, default 4, operand width of the comparator under test.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 1, range 1..15; cycles the operands are held before the flags are sampled.
REQ-003 SHALL have a single clock domain; reset is asynchronous and active-high.
REQ-004 clock  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 start  input  1  one-cycle pulse that begins a sweep; ignored while busy.
REQ-007 A  output  W  operand A driven to the comparator.
REQ-008 B  output  W  operand B driven to the comparator.
REQ-009 A_lt_B, A_eq_B, A_gt_B  input  1 each  result flags returned by the comparator.
REQ-010 busy  output  1  sweep in progress.
REQ-011 done  output  1  sweep finished; held until the next accepted start.
REQ-012 pass  output  1  done with zero mismatches.
REQ-013 err_count  output  2W+1  number of mismatching vectors.
REQ-014 first_err_A, first_err_B  output  W each  operands of the first mismatch; 0 if none.

Function
REQ-015 SHALL sweep vector index i = {A,B} from 0 to 2^(2W)-1, with A in the upper half and B in the lower half.
REQ-016 FSM states: IDLE, DRIVE, SETTLE, CHECK, DONE.
REQ-017 IDLE/DONE + start -> DRIVE with i=0; err_count, first_err_A and first_err_B cleared; done and pass cleared.
REQ-018 DRIVE: A and B are registered from i in one cycle -> SETTLE.
REQ-019 SETTLE: holds for exactly SETTLE_CYCLES cycles -> CHECK.
REQ-020 CHECK: samples all three flags and compares them with the expected one-hot triple from sub-module mag_compare_ref.
REQ-021 Any difference, including a non-one-hot or all-zero triple, is one mismatch.
REQ-022 On a mismatch, err_count increments; on the first mismatch only, first_err_A and first_err_B capture the operands.
REQ-023 CHECK with i = max -> DONE; otherwise i increments and the FSM returns to DRIVE.
REQ-024 Each vector takes 2+SETTLE_CYCLES cycles; a full sweep takes 2^(2W)*(2+SETTLE_CYCLES) cycles.
REQ-025 err_count cannot overflow: its width covers 2^(2W) mismatches.
REQ-026 busy = state not in {IDLE, DONE}.
REQ-027 pass = done AND err_count == 0.
REQ-028 start while busy SHALL have no effect; start in DONE restarts the sweep.
REQ-029 A and B SHALL hold their last values in DONE.

Reset
REQ-030 reset asserted SHALL immediately force state IDLE and drive all outputs (A, B, busy, done, pass, err_count, first_err_*) to 0, including mid-sweep.
REQ-031 The first start after reset release SHALL begin a full sweep from i=0.

Configuration
REQ-032 With MAG_SWEEP_STOP_ON_ERR_EN defined, the first mismatch SHALL send CHECK directly to DONE, leaving err_count=1 and pass=0.
REQ-033 With MAG_SWEEP_STOP_ON_ERR_EN undefined, the sweep SHALL always run all vectors.

Structure
REQ-034 Shared package mag_sweep_pkg SHALL hold the FSM state enum typedef and the default constants for W and SETTLE_CYCLES.
REQ-035 A single sub-module, mag_compare_ref, SHALL compute the expected {lt, eq, gt} from A and B combinationally; there are no other sub-modules.

Verification
REQ-036 Scenario 1: W=4, SETTLE_CYCLES=1, correct comparator model, start pulse -> done after 768 cycles, pass=1, err_count=0.
REQ-037 Scenario 2: A_eq_B tied to 0 -> err_count=16, first_err_A=0, first_err_B=0, pass=0.
REQ-038 Scenario 3: A_gt_B tied to 1 with other flags correct -> err_count=136, first_err at (0,0); with MAG_SWEEP_STOP_ON_ERR_EN defined -> done with err_count=1.
REQ-039 Scenario 4: reset asserted at cycle 300 of a sweep -> all outputs 0 and state IDLE at once; a new start -> full 768-cycle sweep, pass=1.
REQ-040 Scenario 5: start pulsed at cycle 100 while busy -> ignored, done still at cycle 768; SETTLE_CYCLES=3 -> done at cycle 1280.
